// File: rtl/jk_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_ctrl_pkg
// Purpose  : Shared encodings for the JK sequence controller: command codes
//            and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jk_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_UP    = 2'b00,
    CMD_DOWN  = 2'b01,
    CMD_LOAD  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : jk_seq_ctrl_pkg
`default_nettype wire

// File: rtl/jk_seq_ctrl_jk_ff.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff
// Purpose  : Single edge-triggered JK flip-flop with synchronous active-high
//            reset. J/K = 00 hold, 01 clear, 10 set, 11 toggle.
// Ports    : clk   - clock
//            reset - synchronous active-high reset (forces q_o = 0)
//            j_i   - J input
//            k_i   - K input
//            q_o   - flip-flop output
// Revision : 1.0 - initial release
// ============================================================================
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule : jk_ff
`default_nettype wire

// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_ctrl
// Purpose  : Command sequencer driving a bank of WIDTH JK flip-flops. Supports
//            count up / count down for a latched number of steps, parallel
//            load and clear. The controller only ever drives J/K; the register
//            value comes straight from the flip-flop bank.
// Ports    : clk   - clock (rising edge)
//            reset - synchronous active-high reset
//            start - command request, sampled in IDLE only
//            cmd   - 00 up, 01 down, 10 load, 11 clear
//            len   - number of count steps (count commands only)
//            din   - load data
//            q     - register contents
//            busy  - high while in RUN
//            done  - one-cycle pulse while in DONE
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_ctrl
  import jk_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  cmd_e             cmd_q,   cmd_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] din_q,   din_d;

  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] tog_up, tog_dn;

  // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  // Running AND kept in block-local variables to avoid a self-referencing
  // vector in combinational logic.
  always_comb begin : p_toggle
    logic all1;
    logic all0;
    all1   = 1'b1;
    all0   = 1'b1;
    tog_up = '0;
    tog_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog_up[i] = all1;
      tog_dn[i] = all0;
      all1      = all1 & q[i];
      all0      = all0 & ~q[i];
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    j_vec   = '0;
    k_vec   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d   = cmd_e'(cmd);
          cnt_d   = len;
          din_d   = din;
          state_d = RUN;
        end
      end
      RUN: begin
        unique case (cmd_q)
          CMD_UP, CMD_DOWN: begin
            // cnt_q can only be zero in RUN when len was 0: hold that cycle.
            if (cnt_q != '0) begin
              j_vec = (cmd_q == CMD_UP) ? tog_up : tog_dn;
              k_vec = (cmd_q == CMD_UP) ? tog_up : tog_dn;
              cnt_d = cnt_q - WIDTH'(1);
            end
            if (cnt_q <= WIDTH'(1)) begin
              state_d = DONE;
            end
          end
          CMD_LOAD: begin
            j_vec   = din_q;
            k_vec   = ~din_q;
            state_d = DONE;
          end
          CMD_CLEAR: begin
            k_vec   = '1;
            state_d = DONE;
          end
          default: state_d = DONE;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_UP;
      cnt_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
      jk_ff u_ff (
        .clk   (clk),
        .reset (reset),
        .j_i   (j_vec[gi]),
        .k_i   (k_vec[gi]),
        .q_o   (q[gi])
      );
    end
  endgenerate

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule : jk_seq_ctrl
`default_nettype wire

// File: tb/tb_jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_seq_ctrl
// Purpose  : Self-checking bench for jk_seq_ctrl (WIDTH = 4). Table of
//            per-cycle vectors plus hand-written back-to-back and
//            reset-mid-command sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_seq_ctrl;

  localparam int WIDTH = 4;

  typedef struct {
    logic       rst;
    logic       st;
    logic [1:0] cmd;
    logic [3:0] len;
    logic [3:0] din;
    logic [3:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       cmd;
  logic [WIDTH-1:0] len;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  jk_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .cmd   (cmd),
    .len   (len),
    .din   (din),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic s, input logic [1:0] c,
                             input logic [3:0] l, input logic [3:0] d,
                             input logic [3:0] eq, input logic eb, input logic ed);
    vec_t t;
    t.rst = r; t.st = s; t.cmd = c; t.len = l; t.din = d;
    t.eq = eq; t.eb = eb; t.ed = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs (at negedge), take one rising edge, sample at the next negedge.
  task automatic apply(input string tag, input vec_t t);
    reset = t.rst; start = t.st; cmd = t.cmd; len = t.len; din = t.din;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " q"},    32'(q),    32'(t.eq));
    chk({tag, " busy"}, 32'(busy), 32'(t.eb));
    chk({tag, " done"}, 32'(done), 32'(t.ed));
    chk({tag, " busy&done"}, 32'(busy & done), 32'd0);
  endtask

  localparam logic [1:0] UP = 2'b00, DN = 2'b01, LD = 2'b10, CL = 2'b11;

  vec_t tbl[$];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0; cmd = UP; len = '0; din = '0;
    @(negedge clk);

    // rst st cmd len din | q busy done
    tbl.push_back(v(1, 0, UP, 0, 0,    0, 0, 0));
    tbl.push_back(v(1, 1, UP, 5, 0,    0, 0, 0));  // reset beats start
    // UP len=5
    tbl.push_back(v(0, 1, UP, 5, 0,    0, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    1, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    2, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    3, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    4, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 0));
    // LOAD 1110; start in DONE must be ignored
    tbl.push_back(v(0, 1, LD, 0, 14,   5, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,   14, 0, 1));
    tbl.push_back(v(0, 1, CL, 0, 0,   14, 0, 0));
    // UP len=3 with wrap; start in RUN must be ignored
    tbl.push_back(v(0, 1, UP, 3, 0,   14, 1, 0));
    tbl.push_back(v(0, 1, CL, 9, 3,   15, 1, 0));
    tbl.push_back(v(0, 1, CL, 9, 3,    0, 1, 0));
    tbl.push_back(v(0, 1, CL, 9, 3,    1, 0, 1));
    tbl.push_back(v(0, 1, CL, 9, 3,    1, 0, 0));
    // CLEAR
    tbl.push_back(v(0, 1, CL, 0, 0,    1, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    0, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,    0, 0, 0));
    // DOWN len=2 with wrap
    tbl.push_back(v(0, 1, DN, 2, 0,    0, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,   15, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,   14, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,   14, 0, 0));
    // LOAD 0101
    tbl.push_back(v(0, 1, LD, 0, 5,   14, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 0));
    // UP len=0: one hold RUN cycle
    tbl.push_back(v(0, 1, UP, 0, 0,    5, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,    5, 0, 0));
    // DOWN len=1 from 0101, borrow-free single step
    tbl.push_back(v(0, 1, DN, 1, 0,    5, 1, 0));
    tbl.push_back(v(0, 0, UP, 0, 0,    4, 0, 1));
    tbl.push_back(v(0, 0, UP, 0, 0,    4, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // Back-to-back: start held high, UP len=2, from q=0.
    apply("b2b reset", v(1, 0, UP, 0, 0, 0, 0, 0));
    for (int c = 0; c < 12; c++) begin
      int ph;
      int base;
      logic [3:0] eq;
      ph   = c % 4;
      base = 2 * (c / 4);
      eq   = 4'(base + ((ph == 0) ? 0 : (ph == 1) ? 1 : 2));
      apply($sformatf("b2b c%0d", c),
            v(0, 1, UP, 2, 0, eq, (ph <= 1) ? 1'b1 : 1'b0, (ph == 2) ? 1'b1 : 1'b0));
    end

    // Reset during third step of UP len=8 from q=0.
    apply("rst8 pre",  v(1, 0, UP, 0, 0, 0, 0, 0));
    apply("rst8 acc",  v(0, 1, UP, 8, 0, 0, 1, 0));
    apply("rst8 s1",   v(0, 0, UP, 0, 0, 1, 1, 0));
    apply("rst8 s2",   v(0, 0, UP, 0, 0, 2, 1, 0));
    apply("rst8 hit",  v(1, 0, UP, 0, 0, 0, 0, 0));
    for (int c = 0; c < 10; c++) begin
      apply($sformatf("rst8 post%0d", c), v(0, 0, UP, 0, 0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_jk_seq_ctrl
`default_nettype wire

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the register width in bits.
REQ-002 Port clk SHALL be an input of width 1: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port reset SHALL be an input of width 1: synchronous, active-high reset.
REQ-004 Port start SHALL be an input of width 1: command request, sampled only in IDLE.
REQ-005 Port cmd SHALL be an input of width 2: 00 COUNT_UP, 01 COUNT_DOWN, 10 LOAD, 11 CLEAR.
REQ-006 Port len SHALL be an input of width WIDTH: number of count steps, used only by COUNT_UP and COUNT_DOWN.
REQ-007 Port din SHALL be an input of width WIDTH: LOAD data.
REQ-008 Port q SHALL be an output of width WIDTH: the register contents, driven directly from the flip-flop bank.
REQ-009 Port busy SHALL be an output of width 1: high while in RUN.
REQ-010 Port done SHALL be an output of width 1: a one-cycle pulse, high while in DONE.

Function
REQ-011 The register SHALL be WIDTH JK flip-flops; the controller SHALL drive only their J/K inputs and SHALL never write q directly.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the controller SHALL latch cmd, len and din, then go to RUN at the next edge.
REQ-014 In IDLE with start=0, it SHALL stay in IDLE.
REQ-015 start SHALL be ignored in RUN and DONE; there SHALL be no queueing.
REQ-016 Hold (IDLE, DONE, or any cycle with no active step) SHALL drive J=K=0 on all bits, so q is unchanged.
REQ-017 A COUNT_UP step SHALL drive J=K=1 on bit i iff bits 0..i-1 of q are all 1 (bit 0 always toggles); otherwise J=K=0.
REQ-018 A COUNT_DOWN step SHALL drive J=K=1 on bit i iff bits 0..i-1 of q are all 0 (bit 0 always toggles); otherwise J=K=0.
REQ-019 Counting SHALL wrap modulo 2^WIDTH: 1111+1 gives 0000, and 0000-1 gives 1111.
REQ-020 COUNT_UP/COUNT_DOWN with latched len=N>0 SHALL stay N cycles in RUN, performing exactly one step per cycle, then go to DONE.
REQ-021 COUNT_UP/COUNT_DOWN with len=0 SHALL spend one RUN cycle with hold (q unchanged), then go to DONE.
REQ-022 LOAD SHALL spend one RUN cycle driving J=din_latched and K=~din_latched, so q=din after that edge, then go to DONE.
REQ-023 CLEAR SHALL spend one RUN cycle driving J=0 and K=1 on all bits, so q=0, then go to DONE.
REQ-024 DONE SHALL last exactly one cycle, then go to IDLE; a new start SHALL be accepted on the IDLE cycle that follows.
REQ-025 Latency from the start-accept edge to done=1 SHALL be max(N,1)+1 cycles for counts and 2 cycles for LOAD/CLEAR.
REQ-026 busy and done SHALL never be high in the same cycle.
REQ-027 A remaining-step counter of WIDTH bits SHALL decrement once per RUN step; leaving RUN SHALL be decided when the counter is 1 (or on the first RUN cycle when len=0).

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE, q=0, busy=0, done=0 and clear all latched command registers.
REQ-029 reset SHALL override every other input and any command in progress; there SHALL be no partial completion.
REQ-030 The first start sampled SHALL be at the first edge with reset=0.

Structure
REQ-031 A shared package SHALL hold the cmd encodings (CMD_UP, CMD_DOWN, CMD_LOAD, CMD_CLEAR) and the state encoding (IDLE, RUN, DONE).
REQ-032 One sub-module, jk_ff, SHALL exist: a behavioural edge-triggered JK flip-flop with synchronous active-high reset (J/K: 00 hold, 01 clear, 10 set, 11 toggle); it SHALL be instantiated WIDTH times.
REQ-033 J/K generation SHALL be combinational from the latched cmd, q and state, and SHALL contain no latches.

Verification
REQ-034 Bench SHALL cover: reset, then start, cmd=UP, len=5 -> q goes 1,2,3,4,5 on successive cycles; busy high for 5 cycles; done high one cycle later.
REQ-035 Bench SHALL cover: LOAD din=1110, then UP len=3 -> q=1111, 0000, 0001 (wrap); done after the third step.
REQ-036 Bench SHALL cover: CLEAR, then DOWN len=2 -> q=1111, 1110.
REQ-037 Bench SHALL cover: UP len=0 with q=0101 -> one busy cycle, q stays 0101, done pulses.
REQ-038 Bench SHALL cover: start held high continuously with cmd=UP, len=2 -> commands run back to back with one IDLE cycle between each DONE and the next RUN, and no start taken in RUN/DONE.
REQ-039 Bench SHALL cover: reset asserted during the third step of UP len=8 -> next cycle q=0, IDLE, busy=0, done=0; no done pulse follows.
